// File: rtl/param_cascade_timer.sv
// ============================================================================
// Module   : param_cascade_timer
// Purpose  : Two-stage cascaded timer; a fast prescale stage wraps at TIMER_MAX
//            and advances a slow event counter that wraps or stops at COUNT_MAX.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module param_cascade_timer #(
  parameter int TIMER_W   = 4,
  parameter int TIMER_MAX = 9,
  parameter int COUNT_W   = 7,
  parameter int COUNT_MAX = 99
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [COUNT_W-1:0] load_value_i,
  input  logic               mode_i,
  output logic [TIMER_W-1:0] timer_o,
  output logic [COUNT_W-1:0] control_counter_o,
  output logic               tick_o,
  output logic               wrap_o,
  output logic               done_o
);

  localparam logic [TIMER_W-1:0] C_TIMER_MAX = TIMER_W'(TIMER_MAX);
  localparam logic [COUNT_W-1:0] C_COUNT_MAX = COUNT_W'(COUNT_MAX);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;

  always_comb begin
    timer_d = timer_q;
    count_d = count_q;
    done_d  = done_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clear_i) begin
      timer_d = '0;
      count_d = '0;
      done_d  = 1'b0;
    end else if (load_i) begin
      timer_d = '0;
      count_d = (load_value_i > C_COUNT_MAX) ? C_COUNT_MAX : load_value_i;
      done_d  = 1'b0;
    end else if (en_i && !done_q) begin
      if (timer_q != C_TIMER_MAX) begin
        timer_d = timer_q + TIMER_W'(1);
      end else if (count_q != C_COUNT_MAX) begin
        timer_d = '0;
        count_d = count_q + COUNT_W'(1);
        tick_d  = 1'b1;
      end else if (!mode_i) begin
        timer_d = '0;
        count_d = '0;
        tick_d  = 1'b1;
        wrap_d  = 1'b1;
      end else begin
        // One-shot terminal: both stages freeze at their maxima.
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      timer_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign timer_o           = timer_q;
  assign control_counter_o = count_q;
  assign tick_o            = tick_q;
  assign wrap_o            = wrap_q;
  assign done_o            = done_q;

endmodule

`default_nettype wire

// File: tb/tb_param_cascade_timer.sv
// ============================================================================
// Module   : tb_param_cascade_timer
// Purpose  : Directed vector table plus hand sequences for param_cascade_timer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_param_cascade_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, clear = 1'b0, load = 1'b0, mode = 1'b0;
  logic [6:0] load_value = '0;
  logic [3:0] timer;
  logic [6:0] control_counter;
  logic       tick, wrap, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       en, clr, ld;
    logic [6:0] lv;
    logic       mode;
    logic [3:0] t;
    logic [6:0] c;
    logic       tk, wr, dn;
  } vec_t;

  vec_t vecs[$];

  param_cascade_timer #(
    .TIMER_W(4), .TIMER_MAX(9), .COUNT_W(7), .COUNT_MAX(99)
  ) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .clear_i(clear), .load_i(load),
    .load_value_i(load_value), .mode_i(mode), .timer_o(timer),
    .control_counter_o(control_counter), .tick_o(tick), .wrap_o(wrap), .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic void add(logic e, logic cl, logic ld, logic [6:0] lv, logic m,
                              logic [3:0] t, logic [6:0] c, logic tk, logic wr, logic dn);
    vec_t v;
    v.en = e; v.clr = cl; v.ld = ld; v.lv = lv; v.mode = m;
    v.t = t; v.c = c; v.tk = tk; v.wr = wr; v.dn = dn;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag, int t, int c, int tk, int wr, int dn);
    check({tag, ".timer"}, int'(timer), t);
    check({tag, ".counter"}, int'(control_counter), c);
    check({tag, ".tick"}, int'(tick), tk);
    check({tag, ".wrap"}, int'(wrap), wr);
    check({tag, ".done"}, int'(done), dn);
  endtask

  task automatic drive(logic e, logic cl, logic ld, logic [6:0] lv, logic m);
    en = e; clear = cl; load = ld; load_value = lv; mode = m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ticks, wraps, seen99, changed;

    // count from reset, tick after 10th edge
    for (int i = 1; i <= 9; i++) add(1, 0, 0, 0, 0, 4'(i), 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    // run to timer=5, then hold 7 cycles with en low, resume at 6
    for (int i = 1; i <= 5; i++) add(1, 0, 0, 0, 0, 4'(i), 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    // load saturation
    add(0, 0, 1, 120, 0, 0, 99, 0, 0, 0);
    add(0, 0, 1, 100, 0, 0, 99, 0, 0, 0);
    add(0, 0, 1, 99, 0, 0, 99, 0, 0, 0);
    // clear beats load; load beats count
    add(1, 1, 1, 42, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 42, 0, 0, 42, 0, 0, 0);
    for (int i = 1; i <= 9; i++) add(1, 0, 0, 0, 0, 4'(i), 42, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 43, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    #1 reset = 1'b1;
    #14;
    check_all("reset", 0, 0, 0, 0, 0);
    #5 reset = 1'b0;  // released at t=20, away from rising edges

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].mode);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].t, vecs[i].c, vecs[i].tk, vecs[i].wr, vecs[i].dn);
    end

    // Free-running full period
    ticks = 0; wraps = 0; seen99 = 0;
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      step();
      ticks += int'(tick);
      wraps += int'(wrap);
      if (control_counter == 7'd99) seen99 = 1;
    end
    check_all("wrap_end", 0, 0, 1, 1, 0);
    check("wrap_ticks", ticks, 100);
    check("wrap_pulses", wraps, 1);
    check("wrap_seen99", seen99, 1);
    step();
    check_all("wrap_after", 1, 0, 0, 0, 0);

    // One-shot full period
    drive(0, 1, 0, 0, 1);
    step();
    wraps = 0;
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 1000; i++) begin
      step();
      wraps += int'(wrap);
    end
    check_all("oneshot_end", 9, 99, 0, 0, 1);
    check("oneshot_wraps", wraps, 0);
    changed = 0;
    for (int i = 0; i < 50; i++) begin
      drive(1'(i % 3 != 0), 0, 0, 0, 1'(i % 2));
      step();
      if (timer != 4'd9 || control_counter != 7'd99 || !done || tick || wrap) changed++;
    end
    check("oneshot_frozen", changed, 0);
    drive(1, 1, 0, 0, 0);
    step();
    check_all("oneshot_clear", 0, 0, 0, 0, 0);

    // load releases done
    drive(0, 0, 1, 99, 1);
    step();
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step();
    check_all("ld_done", 9, 99, 0, 0, 1);
    drive(0, 0, 1, 5, 0);
    step();
    check_all("ld_release", 0, 5, 0, 0, 0);

    // Asynchronous reset mid-count
    drive(1, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 150; i++) step();
    check_all("pre_rst", 0, 15, 1, 0, 0);
    step();
    #2 reset = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    #199;
    check_all("rst_held", 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    check_all("rst_resume", 1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
